// File: rtl/ltc2308_ctrl.sv
// ltc2308_ctrl: serial master for the LTC2308 8-channel 12-bit ADC.
// Drives adc_convst / adc_sck / adc_sdi, deserialises adc_sdo and returns each
// 12-bit result tagged with the config word the ADC actually used (the one
// sent in the previous frame). All timing is counted in fabric clk cycles.
// Optional free-running channel scan: define LTC2308_CTRL_AUTO_EN to add the
// auto_en input.
module ltc2308_ctrl #(
    parameter int CONVST_HIGH_CYC = 2,
    parameter int CONV_WAIT_CYC   = 82,
    parameter int SCK_HALF_CYC    = 1,
    parameter int CYCLE_CYC       = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cfg,
`ifdef LTC2308_CTRL_AUTO_EN
    input  logic        auto_en,
`endif
    output logic        ready,
    output logic        busy,
    output logic [11:0] data,
    output logic [5:0]  data_cfg,
    output logic        data_valid,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int              CNT_W       = 16;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam int              PH_W        = 8;
    localparam logic [5:0]      PWRUP_CFG   = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST_HI,
        S_CONV_WAIT,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;         // frame counter, 0 at adc_convst rise
    logic             gap_ok_q, gap_ok_d;   // minimum convst-to-convst spacing met
    logic [PH_W-1:0]  ph_q, ph_d;           // cycles spent in current sck phase
    logic [3:0]       bit_q, bit_d;         // index of the current sck rise
    logic [11:0]      sh_q, sh_d;           // incoming sdo bits, MSB first
    logic [5:0]       cfg_sh_q, cfg_sh_d;   // outgoing config bits, MSB first
    logic [5:0]       prev_cfg_q, prev_cfg_d;
    logic [5:0]       tag_q, tag_d;         // word the ADC uses for this frame
    logic             convst_q, convst_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             data_valid_q, data_valid_d;
    logic [11:0]      data_q, data_d;
    logic [5:0]       data_cfg_q, data_cfg_d;

    logic             req_start;
    logic [5:0]       req_cfg;
    logic             accept;

`ifdef LTC2308_CTRL_AUTO_EN
    logic             auto_prev_q, auto_prev_d;
    logic [2:0]       ch_q, ch_d;
    logic [2:0]       ch_cur;
    logic             auto_rise;
`endif

    // Request source: external handshake, or the channel scanner when enabled.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_start = start;
        req_cfg   = cfg;
`ifdef LTC2308_CTRL_AUTO_EN
        auto_rise = auto_en & ~auto_prev_q;
        ch_cur    = auto_rise ? 3'd0 : ch_q;
        auto_prev_d = auto_en;
        if (auto_en) begin
            req_start = 1'b1;
            req_cfg   = {1'b1, ch_cur[0], ch_cur[2:1], 2'b10};
        end
        ch_d = ch_cur;
        if (accept && auto_en) begin
            ch_d = ch_cur + 3'd1;
        end
`endif
    end

    assign accept = req_start & ready_q;

    // Frame sequencer: next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        ph_d         = ph_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        cfg_sh_d     = cfg_sh_q;
        prev_cfg_d   = prev_cfg_q;
        tag_d        = tag_q;
        convst_d     = convst_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        data_cfg_d   = data_cfg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_CONVST_HI;
                    cnt_d      = '0;
                    convst_d   = 1'b1;
                    busy_d     = 1'b1;
                    cfg_sh_d   = req_cfg;
                    // The ADC converts with the previously sent word.
                    tag_d      = prev_cfg_q;
                    prev_cfg_d = req_cfg;
                    sh_d       = '0;
                end
            end
            S_CONVST_HI: begin
                if (cnt_q == CNT_W'(CONVST_HIGH_CYC - 1)) begin
                    state_d  = S_CONV_WAIT;
                    convst_d = 1'b0;
                    sdi_d    = cfg_sh_q[5];
                end
            end
            S_CONV_WAIT: begin
                // First sck rise lands on cycle CONV_WAIT_CYC; sdo MSB is
                // already on the bus, so sample it on this same edge.
                if (cnt_q == CNT_W'(CONV_WAIT_CYC - 1)) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                    bit_d   = '0;
                    ph_d    = '0;
                    sh_d    = {sh_q[10:0], adc_sdo};
                end
            end
            S_SHIFT: begin
                if (ph_q == PH_W'(SCK_HALF_CYC - 1)) begin
                    ph_d = '0;
                    if (sck_q) begin
                        // Falling edge: present the next config bit.
                        sck_d    = 1'b0;
                        cfg_sh_d = {cfg_sh_q[4:0], 1'b0};
                        sdi_d    = cfg_sh_q[4];
                        if (bit_q == 4'd11) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // Rising edge: capture the next data bit.
                        sck_d = 1'b1;
                        bit_d = bit_q + 4'd1;
                        sh_d  = {sh_q[10:0], adc_sdo};
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                data_valid_d = 1'b1;
                data_d       = sh_q;
                data_cfg_d   = tag_q;
                busy_d       = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gap_ok_d = accept ? 1'b0 : (gap_ok_q | (cnt_d >= CNT_W'(CYCLE_CYC - 1)));
        ready_d  = (state_d == S_IDLE) & gap_ok_d & ~busy_d;
    end

    // State and registered outputs; async reset drops every pin at once.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gap_ok_q     <= 1'b1;
            ph_q         <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            cfg_sh_q     <= '0;
            prev_cfg_q   <= PWRUP_CFG;
            tag_q        <= PWRUP_CFG;
            convst_q     <= 1'b0;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            data_cfg_q   <= PWRUP_CFG;
`ifdef LTC2308_CTRL_AUTO_EN
            auto_prev_q  <= 1'b0;
            ch_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_ok_q     <= gap_ok_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            cfg_sh_q     <= cfg_sh_d;
            prev_cfg_q   <= prev_cfg_d;
            tag_q        <= tag_d;
            convst_q     <= convst_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            data_cfg_q   <= data_cfg_d;
`ifdef LTC2308_CTRL_AUTO_EN
            auto_prev_q  <= auto_prev_d;
            ch_q         <= ch_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_cfg   = data_cfg_q;
    assign data_valid = data_valid_q;
    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;

endmodule

// File: doc/ltc2308_ctrl.md
Name: ltc2308_ctrl

Overview:
FPGA-side serial master for the LTC2308 8-channel 12-bit ADC on DE10-Nano. It drives adc_convst, adc_sck and adc_sdi, and deserialises adc_sdo. It accepts one conversion request at a time over a start/ready handshake and returns each 12-bit result tagged with the config word that produced it. It sits between the fabric sampling logic and the ADC pins; all timing is derived from the single fabric clock (50 MHz nominal, 20 ns).

Parameters:
CONVST_HIGH_CYC, 2, clk cycles adc_convst is held high (must give 20–40 ns).
CONV_WAIT_CYC, 82, clk cycles from adc_convst rise to first adc_sck rise (must be ≥1.6 µs).
SCK_HALF_CYC, 1, clk cycles per adc_sck high phase and per low phase (each phase ≥10 ns, period ≥25 ns).
CYCLE_CYC, 100, minimum clk cycles between successive adc_convst rises (2 µs).

Ports:
clk  in  1  fabric clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  conversion request; accepted when start & ready.
cfg  in  6  {S/D, O/S, S1, S0, UNI, SLP}, sampled on acceptance.
ready  out  1  controller can accept start this cycle.
busy  out  1  frame in progress.
data  out  12  conversion result, MSB first off the bus.
data_cfg  out  6  config word that selected the channel for this result.
data_valid  out  1  one-cycle pulse; data and data_cfg valid.
adc_convst  out  1  ADC conversion start.
adc_sck  out  1  ADC shift clock.
adc_sdi  out  1  ADC config serial input.
adc_sdo  in  1  ADC serial data output.

Behaviour:
- Reset is asynchronous. adc_convst, adc_sck, adc_sdi, busy, data_valid = 0. data = 0. data_cfg = 6'b100000. ready = 1 from the first clk after reset_n deasserts. Gap counter is cleared and satisfied.
- Internal prev_cfg resets to 6'b100000, the ADC power-up word. The LTC2308 converts using the config sent in the previous frame, so each result is tagged with prev_cfg. prev_cfg <= cfg at frame acceptance.
- FSM states: IDLE, CONVST_HI, CONV_WAIT, SHIFT, DONE.
- IDLE: ready = gap_ok & ~busy. On start & ready, latch cfg into the shift register, set busy, and go to CONVST_HI. adc_convst rises on the next edge, which is cycle 0 of the frame counter. start while ready = 0 is ignored, with no queueing.
- CONVST_HI: adc_convst high for CONVST_HIGH_CYC cycles, then low. Go to CONV_WAIT.
- CONV_WAIT: adc_sdi = cfg[5] presented. Exit when frame counter = CONV_WAIT_CYC, with adc_sck rising on that edge.
- SHIFT: 12 adc_sck pulses, SCK_HALF_CYC high and SCK_HALF_CYC low each.
  - adc_sdo is sampled on the clk edge that drives adc_sck high. Rise k (0..11) captures bit 11-k.
  - adc_sdi is updated on each adc_sck fall: cfg[4..0] for rises 1..5, then 0 for rises 6..11.
- DONE: the cycle after the last adc_sck fall. Pulse data_valid, drive data and data_cfg = prev_cfg, clear busy, return to IDLE.
- Default frame timing, relative to the adc_convst rise at cycle 0:
  - first adc_sck rise at cycle 82;
  - last rise at 104, last fall at 105;
  - data_valid at 106.
- gap_ok asserts once frame counter ≥ CYCLE_CYC-1. Successive adc_convst rises are therefore ≥CYCLE_CYC apart even if the parameters are shrunk.
- data and data_cfg hold their values until the next data_valid.
- Reset mid-frame: all pins low immediately, the frame is aborted, and no data_valid is produced. The first result after reset carries tag 6'b100000, and consumers discard it.

Optional Feature:
LTC2308_CTRL_AUTO_EN.
- When defined:
  - Adds input auto_en (1 bit).
  - While auto_en = 1, the controller self-issues a start whenever ready, ignoring external start and cfg.
  - The config cycles {1'b1, ch[0], ch[2:1], 2'b10} for ch = 0..7, then wraps 7→0. This is single-ended unipolar in ADC channel order.
  - ch resets to 0 and restarts at 0 on auto_en rising.
  - Deasserting auto_en mid-frame completes the current frame.
- When undefined: no auto_en port, external start only.

Test Plan:
- Reset: hold reset_n=0 with start=1 → all pins 0, data_cfg=6'b100000, ready=1 one cycle after release, no frame starts during reset.
- Single frame: ADC stub CH0=12'hA5C, start with cfg=6'b100010 → adc_convst high 2 cycles, first adc_sck rise 82 cycles after the adc_convst rise, adc_sdi bits 1,0,0,0,1,0 on rises 0..5, data_valid at cycle 106 with data=12'hA5C and data_cfg=6'b100000.
- Pipelining: stub CH3=12'h123, CH5=12'h456; frames cfg CH3, then CH5, then CH0 → second result 12'h123 tagged CH3 word, third result 12'h456 tagged CH5 word.
- Back-to-back: start held high for 4 frames → adc_convst rises every 107 cycles (≥100), no stub timing violations; start pulsed while busy=1 → ignored, no extra frame.
- Abort: reset_n low during the 6th adc_sck high → adc_sck, adc_convst and adc_sdi low that instant, no data_valid; after release, a new frame completes correctly.
- Auto (macro defined): auto_en=1 for 9 frames → data_cfg tags follow power-up word, then ch0..ch7 words, and data matches the stub channel pattern.
